adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin controller that shares one 32-bit ripple-carry adder among NREQ requesters. Grants one request at a time and drives the held operands onto the shared adder. Waits a fixed number of settle cycles for the carry chain to resolve, then registers the sum, carryout and signed overflow into a response with valid/ready handshake. Sits between the requesting datapath units and the single adder instance.

## Interface
- NREQ, 4: number of requesters; legal range 1..8.
- IDW, $clog2(NREQ), minimum 1: width of the requester index.
- SETTLE_CYCLES, 2: cycles operands are held on the adder before the result is sampled; must be ≥1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- req_a  in  NREQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  NREQ*32  operand B; same packing as req_a.
- add_a  out  32  operand A to the shared adder (registered).
- add_b  out  32  operand B to the shared adder (registered).
- add_sum  in  32  sum from the shared adder.
- add_cout  in  1  carryout from the shared adder.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_sum  out  32  registered sum.
- rsp_cout  out  1  registered carryout.
- rsp_ovf  out  1  signed overflow: (add_a[31]==add_b[31]) & (add_sum[31]!=add_a[31]), sampled with the sum.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready is the one-hot grant among asserted req_valid bits, searched from ptr upward with wrap from NREQ-1 to 0.
  - All req_ready bits are zero if no req_valid is set, and in every other state.
  - req_ready is combinational from req_valid, ptr and state.
  - On transfer: latch the winner's req_a/req_b into add_a/add_b, latch the index into rsp_id, load cnt = SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - If cnt≠0, decrement.
  - If cnt==0, capture add_sum, add_cout and the overflow term into rsp_sum, rsp_cout and rsp_ovf; set rsp_valid; go to RESP.
- RESP:
  - Hold all rsp_* outputs stable.
  - On rsp_valid & rsp_ready: clear rsp_valid, set ptr = rsp_id+1 (wrap to 0 after NREQ-1), go to IDLE.
- add_a/add_b change only on a transfer edge. They remain unchanged through SETTLE, RESP and IDLE until the next transfer.
- No bypass: a handshake in RESP and a pending request in the same cycle produce a grant only in the following IDLE cycle.
- Requesters must hold req_valid and operands until granted. A req_valid deasserted before grant is simply not considered.
- NREQ=1: ptr is constant 0; the grant equals req_valid[0] in IDLE.

## Timing
- Reset (async assert, synchronous release): state=IDLE, ptr=0, cnt=0.
- Output reset values: add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0, req_ready=0.
- Latency: transfer at edge E; rsp_valid is high after edge E+SETTLE_CYCLES.
  - add_a/add_b are stable for exactly SETTLE_CYCLES full cycles before the capture edge.
- Minimum issue interval is SETTLE_CYCLES+2 cycles per operation, with rsp_ready held high.
- rsp_ready low stalls indefinitely in RESP; no new grant is issued.
- Reset asserted mid-operation aborts the operation: the response is lost and outputs return to reset values immediately, with no clock required.

## Configuration
- ADD_ARB_FIXED_PRI_EN defined: fixed priority, lowest asserted index always wins; ptr is not implemented (reads as 0).
- Undefined (default): round-robin as described above.

## Test plan
- Single request: req_valid=0001, a=1, b=0xFFFFFFFF, SETTLE_CYCLES=2 -> req_ready=0001 for 1 cycle; rsp_valid 2 edges after transfer; rsp_sum=0, rsp_cout=1, rsp_ovf=0, rsp_id=0.
- Overflow: a=0x7FFFFFFF, b=2 -> rsp_sum=0x80000001, rsp_ovf=1, rsp_cout=0. Also a=0x80000000, b=0xFFFFFFFB -> rsp_sum=0x7FFFFFFB, rsp_ovf=1, rsp_cout=1.
- Round-robin fairness: req_valid=1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3, with rsp_id matching. With ADD_ARB_FIXED_PRI_EN -> 0 every time.
- Backpressure: rsp_ready=0 for 10 cycles in RESP while req_valid=0110 -> rsp_* stable, req_ready=0000, add_a/add_b unchanged. After rsp_ready=1, the next grant follows one cycle later.
- Reset mid-SETTLE: assert rst_n=0 one cycle after transfer -> all outputs at reset values immediately. After release with req_valid=0100 -> grant 0100 (ptr=0 search).
- Settle check with SETTLE_CYCLES=3 and an adder model delaying add_sum by 3 cycles: a=0xFFFBFFFF, b=1 -> rsp_sum=0xFFFC0000, rsp_cout=0.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one external 32-bit adder among NREQ requesters, one operation at a time.
// Define ADD_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module adder_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned IDW           = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_a,
  input  logic [NREQ*32-1:0]  req_b,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  input  logic [31:0]         add_sum,
  input  logic                add_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_sum,
  output logic                rsp_cout,
  output logic                rsp_ovf,
  output logic                busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [IDW:0]    pos;
  logic [DW-1:0]   add_a_next, add_b_next, rsp_sum_next;
  logic            rsp_valid_next, rsp_cout_next, rsp_ovf_next;
  logic [IDW-1:0]  rsp_id_next;
  logic            ovf_c;

  // Rotating search: first asserted req_valid at or above ptr, wrapping past NREQ-1.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
      if (!grant_any && req_valid[pos[IDW-1:0]]) begin
        grant[pos[IDW-1:0]] = 1'b1;
        grant_id            = pos[IDW-1:0];
        grant_any           = 1'b1;
      end
    end
  end

  assign ovf_c = (add_a[DW-1] == add_b[DW-1]) && (add_sum[DW-1] != add_a[DW-1]);
  assign busy  = (state != IDLE);

  // Next-state and datapath updates.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    add_a_next     = add_a;
    add_b_next     = add_b;
    rsp_valid_next = rsp_valid;
    rsp_id_next    = rsp_id;
    rsp_sum_next   = rsp_sum;
    rsp_cout_next  = rsp_cout;
    rsp_ovf_next   = rsp_ovf;
    req_ready      = '0;
    unique case (state)
      IDLE: begin
        // Gated by rst_n so the grant reads zero while reset is held.
        if (rst_n) req_ready = grant;
        if (grant_any) begin
          add_a_next  = req_a[{grant_id, 5'b0} +: DW];
          add_b_next  = req_b[{grant_id, 5'b0} +: DW];
          rsp_id_next = grant_id;
          cnt_next    = CW'(SETTLE_CYCLES - 1);
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          rsp_sum_next   = add_sum;
          rsp_cout_next  = add_cout;
          rsp_ovf_next   = ovf_c;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      add_a     <= add_a_next;
      add_b     <= add_b_next;
      rsp_valid <= rsp_valid_next;
      rsp_id    <= rsp_id_next;
      rsp_sum   <= rsp_sum_next;
      rsp_cout  <= rsp_cout_next;
      rsp_ovf   <= rsp_ovf_next;
    end
  end

`ifdef ADD_ARB_FIXED_PRI_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] ptr_next;

  // Pointer moves just past the requester whose response was accepted.
  always_comb begin
    ptr_next = ptr;
    if (state == RESP && rsp_valid && rsp_ready)
      ptr_next = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_next;
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (SETTLE_CYCLES=2 with an ideal adder,
// plus a SETTLE_CYCLES=3 instance driving a two-stage pipelined adder model).
module tb_adder_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  add_a, add_b, add_sum, rsp_sum;
  logic         add_cout, rsp_valid, rsp_ready, rsp_cout, rsp_ovf, busy;
  logic [1:0]   rsp_id;

  logic [3:0]   req_valid3, req_ready3;
  logic [127:0] req_a3, req_b3;
  logic [31:0]  add_a3, add_b3, add_sum3, rsp_sum3;
  logic         add_cout3, rsp_valid3, rsp_ready3, rsp_cout3, rsp_ovf3, busy3;
  logic [1:0]   rsp_id3;
  logic [32:0]  d1, d2;

  int checks = 0;
  int errors = 0;

  adder_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  adder_arbiter #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .add_a(add_a3), .add_b(add_b3),
    .add_sum(add_sum3), .add_cout(add_cout3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3), .rsp_ovf(rsp_ovf3), .busy(busy3)
  );

  // Ideal adder for the main instance.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  // Slow adder: result valid only in the third cycle after the operands change.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= {1'b0, add_a3} + {1'b0, add_b3};
      d2 <= d1;
    end
  end
  assign {add_cout3, add_sum3} = d2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete operation with rsp_ready asserted as soon as the response appears.
  task automatic op(input logic [3:0] vld, input logic [3:0] gnt, input logic [1:0] id,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum,
                    input logic cout, input logic ovf);
    req_valid = vld;
    #1;
    chk("grant", req_ready, gnt);
    tick();
    chk("busy_settle", busy, 1);
    chk("add_a", add_a, a);
    chk("add_b", add_b, b);
    chk("no_grant_settle", req_ready, 0);
    tick();
    chk("rsp_early", rsp_valid, 0);
    tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_sum", rsp_sum, sum);
    chk("rsp_cout", rsp_cout, cout);
    chk("rsp_ovf", rsp_ovf, ovf);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    chk("rsp_cleared", rsp_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
    #12;
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_no_req", req_ready, 0);

    // Round-robin fairness: all four requesting.
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'(10 + i);
      req_b[32*i +: 32] = 32'(4096 * i);
    end
    for (int k = 0; k < 8; k++)
      op(4'hF, 4'(1 << (k % 4)), 2'(k % 4), 32'(10 + k % 4), 32'(4096 * (k % 4)),
         32'(10 + k % 4 + 4096 * (k % 4)), 1'b0, 1'b0);

    // Single request with carry out, then both signed-overflow directions.
    req_a[31:0] = 32'h0000_0001; req_b[31:0] = 32'hFFFF_FFFF;
    op(4'b0001, 4'b0001, 2'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    req_a[31:0] = 32'h7FFF_FFFF; req_b[31:0] = 32'h0000_0002;
    op(4'b0001, 4'b0001, 2'd0, 32'h7FFF_FFFF, 32'h0000_0002, 32'h8000_0001, 1'b0, 1'b1);
    req_a[31:0] = 32'h8000_0000; req_b[31:0] = 32'hFFFF_FFFB;
    op(4'b0001, 4'b0001, 2'd0, 32'h8000_0000, 32'hFFFF_FFFB, 32'h7FFF_FFFB, 1'b1, 1'b1);

    // Backpressure: requester 1 served (ptr=1), response held for 10 cycles.
    req_a[63:32] = 32'h1111_1111; req_b[63:32] = 32'h2222_2222;
    req_a[95:64] = 32'hA000_0000; req_b[95:64] = 32'hA000_0000;
    req_valid = 4'b0110;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick();
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_sum", rsp_sum, 32'h3333_3333);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_add_a", add_a, 32'h1111_1111);
      chk("bp_add_b", add_b, 32'h2222_2222);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_released", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0100);
    op(4'b0110, 4'b0100, 2'd2, 32'hA000_0000, 32'hA000_0000, 32'h4000_0000, 1'b1, 1'b1);

    // Reset one cycle after a transfer, with ptr=3 beforehand.
    req_a[127:96] = 32'd5; req_b[127:96] = 32'd6;
    req_valid = 4'b1000;
    #1;
    chk("pre_rst_grant", req_ready, 4'b1000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    req_valid = 4'b1100;
    @(negedge clk) rst_n = 1'b1;
    op(4'b1100, 4'b0100, 2'd2, 32'hA000_0000, 32'hA000_0000, 32'h4000_0000, 1'b1, 1'b1);

    // Three settle cycles against the slow adder.
    req_a3[31:0] = 32'hFFFB_FFFF; req_b3[31:0] = 32'h0000_0001;
    req_valid3 = 4'b0001;
    #1;
    chk("s3_grant", req_ready3, 4'b0001);
    tick();
    req_valid3 = 4'b0000;
    chk("s3_busy", busy3, 1);
    tick();
    chk("s3_rsp_e1", rsp_valid3, 0);
    tick();
    chk("s3_rsp_e2", rsp_valid3, 0);
    tick();
    chk("s3_rsp_valid", rsp_valid3, 1);
    chk("s3_rsp_sum", rsp_sum3, 32'hFFFC_0000);
    chk("s3_rsp_cout", rsp_cout3, 0);
    chk("s3_rsp_ovf", rsp_ovf3, 0);
    chk("s3_rsp_id", rsp_id3, 0);
    rsp_ready3 = 1'b1;
    tick();
    rsp_ready3 = 1'b0;
    chk("s3_rsp_cleared", rsp_valid3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
